// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU operation sequencer: FSM state codes and reset constants.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    A_DRV  = 4'd1,
    A_LAT  = 4'd2,
    A_REL  = 4'd3,
    B_DRV  = 4'd4,
    B_LAT  = 4'd5,
    B_REL  = 4'd6,
    WB_DRV = 4'd7,
    WB_WR  = 4'd8,
    WB_REL = 4'd9,
    DONE   = 4'd10
  } state_e;

  // Wide enough for any OP_W up to 16; truncated to OP_W at the use site.
  localparam logic [15:0] ALU_CTL_RST    = 16'hFFFF;
  localparam int          DEFAULT_FSM_ID = 0;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Dispatcher-side bundle of the sequencer pins; flags_latch_en exists only with ALU_SEQ_FLAGS_EN.
// Handshake: a launch is requested by holding FSM_start==FSM_ID while busy is low; done pulses once per launch.
interface alu_op_sequencer_if #(
  parameter int ADDR_W  = 6,
  parameter int OP_W    = 4,
  parameter int START_W = 4
);
  logic [START_W-1:0] FSM_start;
  logic [OP_W-1:0]    opcode;
  logic [ADDR_W-1:0]  param1;
  logic [ADDR_W-1:0]  param2;
  logic               bus_register_out_en;
  logic               bus_register_input_en;
  logic [ADDR_W-1:0]  register_addr;
  logic               I0_bus_output_en;
  logic               I0_bus_input_en;
  logic               latched_bus1_en;
  logic               latched_bus2_en;
  logic               alu_bus_out_en;
  logic [OP_W-1:0]    alu_control;
  logic               busy;
  logic               done;
`ifdef ALU_SEQ_FLAGS_EN
  logic               flags_latch_en;
`endif

  modport master (
    output FSM_start, opcode, param1, param2,
    input  bus_register_out_en, bus_register_input_en, register_addr,
           I0_bus_output_en, I0_bus_input_en, latched_bus1_en, latched_bus2_en,
           alu_bus_out_en, alu_control, busy, done
`ifdef ALU_SEQ_FLAGS_EN
    , input flags_latch_en
`endif
  );

  modport slave (
    input  FSM_start, opcode, param1, param2,
    output bus_register_out_en, bus_register_input_en, register_addr,
           I0_bus_output_en, I0_bus_input_en, latched_bus1_en, latched_bus2_en,
           alu_bus_out_en, alu_control, busy, done
`ifdef ALU_SEQ_FLAGS_EN
    , output flags_latch_en
`endif
  );

endinterface

// File: rtl/alu_seq_route.sv
// Operand index decoder: indices below NUM_REGS address the register file, the rest the I/O port.
module alu_seq_route #(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 4
) (
  input  logic [ADDR_W-1:0] idx,
  output logic              reg_en,
  output logic              io_en
);

  always_comb begin
    reg_en = (int'(idx) < NUM_REGS);
    io_en  = !reg_en;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU instruction over the shared bus: fetch A, fetch B (skipped if unary), write back, done.
// Optional ALU_SEQ_FLAGS_EN adds flags_latch_en, pulsed while the result is written back.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int                ADDR_W     = 6,
  parameter int                OP_W       = 4,
  parameter int                NUM_REGS   = 4,
  parameter int                START_W    = 4,
  parameter int                FSM_ID     = DEFAULT_FSM_ID,
  parameter logic [2**OP_W-1:0] UNARY_MASK = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [START_W-1:0] FSM_start,
  input  logic [OP_W-1:0]    opcode,
  input  logic [ADDR_W-1:0]  param1,
  input  logic [ADDR_W-1:0]  param2,
  output logic               bus_register_out_en,
  output logic               bus_register_input_en,
  output logic [ADDR_W-1:0]  register_addr,
  output logic               I0_bus_output_en,
  output logic               I0_bus_input_en,
  output logic               latched_bus1_en,
  output logic               latched_bus2_en,
  output logic               alu_bus_out_en,
  output logic [OP_W-1:0]    alu_control,
  output logic               busy,
`ifdef ALU_SEQ_FLAGS_EN
  output logic               flags_latch_en,
`endif
  output logic               done
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   opc_q, opc_d;
  logic [ADDR_W-1:0] opa_q, opa_d;
  logic [ADDR_W-1:0] opb_q, opb_d;
  logic [OP_W-1:0]   alu_ctl_q, alu_ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              src_drv, dst_wr;
  logic [ADDR_W-1:0] src_idx;
  logic              src_reg, src_io, dst_reg, dst_io;

  // Operand B is the bus source only during its two fetch cycles.
  assign src_idx = (state_q == B_DRV || state_q == B_LAT) ? opb_q : opa_q;

  alu_seq_route #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_src_route (
    .idx    (src_idx),
    .reg_en (src_reg),
    .io_en  (src_io)
  );

  alu_seq_route #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dst_route (
    .idx    (opa_q),
    .reg_en (dst_reg),
    .io_en  (dst_io)
  );

  assign bus_register_out_en   = src_drv & src_reg;
  assign I0_bus_output_en      = src_drv & src_io;
  assign bus_register_input_en = dst_wr & dst_reg;
  assign I0_bus_input_en       = dst_wr & dst_io;

  always_comb begin
    state_d         = state_q;
    opc_d           = opc_q;
    opa_d           = opa_q;
    opb_d           = opb_q;
    alu_ctl_d       = alu_ctl_q;
    src_drv         = 1'b0;
    dst_wr          = 1'b0;
    latched_bus1_en = 1'b0;
    latched_bus2_en = 1'b0;
    alu_bus_out_en  = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
    flags_latch_en  = 1'b0;
`endif
    register_addr   = addr_q;
    alu_control     = alu_ctl_q;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (FSM_start == START_W'(FSM_ID)) begin
          state_d = A_DRV;
          opc_d   = opcode;
          opa_d   = param1;
          opb_d   = param2;
        end
      end
      A_DRV: begin
        src_drv       = 1'b1;
        register_addr = opa_q;
        state_d       = A_LAT;
      end
      A_LAT: begin
        src_drv         = 1'b1;
        register_addr   = opa_q;
        latched_bus1_en = 1'b1;
        alu_control     = opc_q;
        alu_ctl_d       = opc_q;
        state_d         = A_REL;
      end
      A_REL:  state_d = UNARY_MASK[opc_q] ? WB_DRV : B_DRV;
      B_DRV: begin
        src_drv       = 1'b1;
        register_addr = opb_q;
        state_d       = B_LAT;
      end
      B_LAT: begin
        src_drv         = 1'b1;
        register_addr   = opb_q;
        latched_bus2_en = 1'b1;
        state_d         = B_REL;
      end
      B_REL:  state_d = WB_DRV;
      WB_DRV: begin
        alu_bus_out_en = 1'b1;
        register_addr  = opa_q;
        state_d        = WB_WR;
      end
      WB_WR: begin
        alu_bus_out_en = 1'b1;
        register_addr  = opa_q;
        dst_wr         = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
        flags_latch_en = 1'b1;
`endif
        state_d        = WB_REL;
      end
      WB_REL: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
    addr_d = register_addr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      opc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      alu_ctl_q <= OP_W'(ALU_CTL_RST);
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      alu_ctl_q <= alu_ctl_d;
      addr_q    <= addr_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: each launch pushes its cycle-by-cycle expected outputs.
module tb_alu_op_sequencer;

  localparam int          ADDR_W   = 6;
  localparam int          OP_W     = 4;
  localparam int          NUM_REGS = 4;
  localparam int          START_W  = 4;
  localparam int          FSM_ID   = 0;
  localparam logic [15:0] UNARY_TB = 16'h0200;
  localparam logic [3:0]  IDLE_SEL = 4'd3;
`ifdef ALU_SEQ_FLAGS_EN
  localparam int W = 21;
`else
  localparam int W = 20;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_op_sequencer_if #(.ADDR_W(ADDR_W), .OP_W(OP_W), .START_W(START_W)) bus_if ();

  alu_op_sequencer #(
    .ADDR_W(ADDR_W), .OP_W(OP_W), .NUM_REGS(NUM_REGS), .START_W(START_W),
    .FSM_ID(FSM_ID), .UNARY_MASK(UNARY_TB)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .FSM_start             (bus_if.FSM_start),
    .opcode                (bus_if.opcode),
    .param1                (bus_if.param1),
    .param2                (bus_if.param2),
    .bus_register_out_en   (bus_if.bus_register_out_en),
    .bus_register_input_en (bus_if.bus_register_input_en),
    .register_addr         (bus_if.register_addr),
    .I0_bus_output_en      (bus_if.I0_bus_output_en),
    .I0_bus_input_en       (bus_if.I0_bus_input_en),
    .latched_bus1_en       (bus_if.latched_bus1_en),
    .latched_bus2_en       (bus_if.latched_bus2_en),
    .alu_bus_out_en        (bus_if.alu_bus_out_en),
    .alu_control           (bus_if.alu_control),
    .busy                  (bus_if.busy),
`ifdef ALU_SEQ_FLAGS_EN
    .flags_latch_en        (bus_if.flags_latch_en),
`endif
    .done                  (bus_if.done)
  );

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  string        cur_tag  = "reset";
  logic [3:0]   m_alu    = 4'hF;
  logic [5:0]   m_addr   = 6'd0;
  int           prev_drv = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Field order: ro ri io ii l1 l2 ao busy done addr[5:0] alu[3:0], flags on top when enabled.
  function automatic logic [W-1:0] pack(bit ro, bit ri, bit io, bit ii, bit l1, bit l2, bit ao,
                                        bit bz, bit dn, bit fl, logic [5:0] addr, logic [3:0] alu);
    logic [W-1:0] v;
    v = '0;
    v[19:0] = {ro, ri, io, ii, l1, l2, ao, bz, dn, addr, alu};
`ifdef ALU_SEQ_FLAGS_EN
    v[20] = fl;
`else
    if (fl) v = v;
`endif
    return v;
  endfunction

  function automatic logic [W-1:0] observed();
    bit fl;
`ifdef ALU_SEQ_FLAGS_EN
    fl = bus_if.flags_latch_en;
`else
    fl = 1'b0;
`endif
    return pack(bus_if.bus_register_out_en, bus_if.bus_register_input_en,
                bus_if.I0_bus_output_en, bus_if.I0_bus_input_en,
                bus_if.latched_bus1_en, bus_if.latched_bus2_en, bus_if.alu_bus_out_en,
                bus_if.busy, bus_if.done, fl, bus_if.register_addr, bus_if.alu_control);
  endfunction

  function automatic logic [W-1:0] idle_vec();
    return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_addr, m_alu);
  endfunction

  // Expected timeline of one instruction, cycles 1..n after the launch edge.
  task automatic push_trace(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                            output int n);
    bit unary, s_a, s_b, ro, io, ri, ii, fl;
    int w;
    logic [5:0] addr;
    logic [3:0] alu;
    unary = UNARY_TB[op];
    n = unary ? 7 : 10;
    w = unary ? 4 : 7;
    for (int c = 1; c <= n; c++) begin
      s_a  = (c == 1 || c == 2);
      s_b  = !unary && (c == 4 || c == 5);
      ro   = (s_a && a < NUM_REGS) || (s_b && b < NUM_REGS);
      io   = (s_a && a >= NUM_REGS) || (s_b && b >= NUM_REGS);
      ri   = (c == w + 1) && (a < NUM_REGS);
      ii   = (c == w + 1) && (a >= NUM_REGS);
      fl   = (c == w + 1);
      addr = (!unary && c >= 4 && c <= 6) ? b : a;
      alu  = (c >= 2) ? op : m_alu;
      exp_q.push_back(pack(ro, ri, io, ii, c == 2, !unary && c == 5, c == w || c == w + 1,
                           1'b1, c == w + 3, fl, addr, alu));
    end
    m_addr = a;
    m_alu  = op;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    cur_tag = tag;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(idle_vec());
      @(posedge clock); #1;
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b,
                        input bit mutate, input string tag);
    int n;
    cur_tag          = tag;
    bus_if.opcode    = op;
    bus_if.param1    = a;
    bus_if.param2    = b;
    bus_if.FSM_start = START_W'(FSM_ID);
    exp_q.push_back(idle_vec());
    @(posedge clock); #1;
    push_trace(op, a, b, n);
    bus_if.FSM_start = IDLE_SEL;
    for (int c = 1; c <= n; c++) begin
      if (mutate && c == 3) begin
        bus_if.opcode    = ~op;
        bus_if.param1    = b;
        bus_if.param2    = a;
        bus_if.FSM_start = START_W'(FSM_ID);
      end
      if (mutate && c == n) bus_if.FSM_start = IDLE_SEL;
      @(posedge clock); #1;
    end
    check({"drain_", tag}, W'(exp_q.size()), '0);
  endtask

  task automatic reset_mid(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b);
    int n;
    cur_tag          = "t5_pre_reset";
    bus_if.opcode    = op;
    bus_if.param1    = a;
    bus_if.param2    = b;
    bus_if.FSM_start = START_W'(FSM_ID);
    exp_q.push_back(idle_vec());
    @(posedge clock); #1;
    push_trace(op, a, b, n);
    bus_if.FSM_start = IDLE_SEL;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;  // asserted during cycle 5 (B_LAT)
    @(posedge clock); #1;
    exp_q.delete();
    m_addr  = 6'd0;
    m_alu   = 4'hF;
    cur_tag = "t5_after_reset_edge";
    exp_q.push_back(idle_vec());
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  always @(negedge clock) begin
    int nd, cur;
    bit viol;
    nd  = int'(bus_if.bus_register_out_en) + int'(bus_if.I0_bus_output_en) + int'(bus_if.alu_bus_out_en);
    cur = bus_if.bus_register_out_en ? 1 : bus_if.I0_bus_output_en ? 2 : bus_if.alu_bus_out_en ? 3 : 0;
    viol = (nd > 1) || (cur != 0 && prev_drv != 0 && cur != prev_drv);
    check("bus_excl", W'(viol), '0);
    prev_drv = cur;
    if (exp_q.size() > 0) check(cur_tag, observed(), exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r_op;
    logic [5:0] r_a, r_b;
    bus_if.FSM_start = IDLE_SEL;
    bus_if.opcode    = '0;
    bus_if.param1    = '0;
    bus_if.param2    = '0;
    reset            = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    cur_tag = "reset_state";
    exp_q.push_back(idle_vec());
    @(posedge clock); #1;
    reset = 1'b0;
    idle_cycles(2, "idle_after_reset");

    run_op(4'h2, 6'd1, 6'd2, 1'b0, "t1_binary_reg");
    idle_cycles(2, "t1_idle");
    run_op(4'h5, 6'd5, 6'd6, 1'b0, "t2_binary_io");
    idle_cycles(1, "t2_idle");
    run_op(4'h9, 6'd1, 6'd3, 1'b0, "t3_unary_reg");
    run_op(4'h9, 6'd7, 6'd0, 1'b0, "t3_unary_io");
    bus_if.FSM_start = IDLE_SEL;
    idle_cycles(20, "t4_wrong_id");
    run_op(4'h6, 6'd2, 6'd5, 1'b1, "t4_mutate");
    idle_cycles(2, "t4_idle");
    run_op(4'h1, 6'd3, 6'd4, 1'b0, "boundary_3_4");
    run_op(4'h7, 6'd4, 6'd3, 1'b0, "boundary_4_3");
    reset_mid(4'h2, 6'd3, 6'd1);
    run_op(4'h3, 6'd0, 6'd3, 1'b0, "t5_relaunch");

    for (int i = 0; i < 6; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = 6'($urandom_range(0, 7));
      r_b  = 6'($urandom_range(0, 7));
      run_op(r_op, r_a, r_b, 1'b0, "random_op");
      idle_cycles(int'($urandom_range(0, 2)), "random_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
